// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM; MC_CTRL_TRAP_EN makes undefined instructions trap
module mc_ctrl #(
  parameter int MEM_LAT  = 1,
  parameter int ALUCTR_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                PCWr,
  output logic                IRWr,
  output logic                RegWr,
  output logic                MemWr,
  output logic [1:0]          RegDst,
  output logic                ALUSrc,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          Ext_op,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [1:0]          nPC_sel,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  logic       is_addu, is_subu, is_or, is_slt, is_jr;
  logic       is_ori, is_lui, is_lw, is_lh, is_sw, is_beq, is_j, is_jal;
  logic       is_rtype_alu, is_alu, is_mem, is_valid;
  logic [3:0] cnt;
  logic       last_wait;
  logic [2:0] next_state;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, done;

  // instruction class decode
  always_comb begin
    is_addu      = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu      = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    is_or        = (opcode == OP_RTYPE) && (funct == FN_OR);
    is_slt       = (opcode == OP_RTYPE) && (funct == FN_SLT);
    is_jr        = (opcode == OP_RTYPE) && (funct == FN_JR);
    is_ori       = (opcode == OP_ORI);
    is_lui       = (opcode == OP_LUI);
    is_lw        = (opcode == OP_LW);
    is_lh        = (opcode == OP_LH);
    is_sw        = (opcode == OP_SW);
    is_beq       = (opcode == OP_BEQ);
    is_j         = (opcode == OP_J);
    is_jal       = (opcode == OP_JAL);
    is_rtype_alu = is_addu | is_subu | is_or | is_slt;
    is_alu       = is_rtype_alu | is_ori | is_lui;
    is_mem       = is_lw | is_lh | is_sw;
    is_valid     = is_alu | is_mem | is_beq | is_j | is_jal | is_jr;
  end

  // datapath selects depend only on the instruction, never on the state
  always_comb begin
    RegDst   = is_jal ? 2'd2 : (is_rtype_alu ? 2'd1 : 2'd0);
    ALUSrc   = is_ori | is_lui | is_mem;
    MemtoReg = is_lw ? 2'd1 : (is_jal ? 2'd2 : (is_lh ? 2'd3 : 2'd0));
    Ext_op   = is_lui ? 2'd2 : ((is_mem | is_beq) ? 2'd1 : 2'd0);
    if (is_subu || is_beq)     ALUctr = ALUCTR_W'(1);
    else if (is_or || is_ori)  ALUctr = ALUCTR_W'(2);
    else if (is_lui)           ALUctr = ALUCTR_W'(3);
    else if (is_slt)           ALUctr = ALUCTR_W'(4);
    else                       ALUctr = ALUCTR_W'(0);
  end

  assign last_wait = (cnt == LAST_WAIT);

  // next-state and raw strobe generation
  always_comb begin
    next_state = S_FETCH;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    nPC_sel    = 2'd0;
    case (state)
      S_FETCH: begin
        next_state = S_FETCH;
        if (last_wait) begin
          ir_wr      = 1'b1;
          pc_wr      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_wr   = 1'b1;
          nPC_sel = 2'd2;
          reg_wr  = is_jal;
        end else if (is_jr) begin
          pc_wr   = 1'b1;
          nPC_sel = 2'd3;
        end else if (!is_valid) begin
`ifdef MC_CTRL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;
`endif
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          next_state = S_WB;
        end else if (is_mem) begin
          next_state = S_MEM;
        end else if (is_beq) begin
          pc_wr   = zero;
          nPC_sel = 2'd1;
        end
      end
      S_MEM: begin
        next_state = S_MEM;
        if (last_wait) begin
          mem_wr     = is_sw;
          next_state = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_wr = 1'b1;
      end
      S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
        next_state = S_TRAP;
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase
    done = (next_state == S_FETCH) &&
           (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB);
  end

  // reset silences every strobe immediately, not just from the next edge
  always_comb begin
    PCWr       = pc_wr  & ~reset;
    IRWr       = ir_wr  & ~reset;
    RegWr      = reg_wr & ~reset;
    MemWr      = mem_wr & ~reset;
    instr_done = done   & ~reset;
  end

  // state, wait counter and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      cnt       <= 4'd0;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if ((state == S_FETCH || state == S_MEM) && !last_wait) cnt <= cnt + 4'd1;
      else                                                    cnt <= 4'd0;
      if (done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, b_reset, c_reset;
  logic [5:0] a_op, a_fn, b_op, b_fn, c_op, c_fn;
  logic       a_zero, b_zero, c_zero;

  logic        a_PCWr, a_IRWr, a_RegWr, a_MemWr, a_ALUSrc, a_done;
  logic [1:0]  a_RegDst, a_MemtoReg, a_Ext_op, a_nPC_sel;
  logic [2:0]  a_ALUctr, a_state;
  logic [3:0]  a_cnt;
  logic        b_PCWr, b_IRWr, b_RegWr, b_MemWr, b_ALUSrc, b_done;
  logic [1:0]  b_RegDst, b_MemtoReg, b_Ext_op, b_nPC_sel;
  logic [2:0]  b_ALUctr, b_state;
  logic [15:0] b_cnt;
  logic        c_PCWr, c_IRWr, c_RegWr, c_MemWr, c_ALUSrc, c_done;
  logic [1:0]  c_RegDst, c_MemtoReg, c_Ext_op, c_nPC_sel;
  logic [2:0]  c_ALUctr, c_state;
  logic [15:0] c_cnt;

  mc_ctrl #(.MEM_LAT(1), .ALUCTR_W(3), .CNT_W(4)) u_a (
    .clk(clk), .reset(a_reset), .opcode(a_op), .funct(a_fn), .zero(a_zero),
    .PCWr(a_PCWr), .IRWr(a_IRWr), .RegWr(a_RegWr), .MemWr(a_MemWr),
    .RegDst(a_RegDst), .ALUSrc(a_ALUSrc), .MemtoReg(a_MemtoReg), .Ext_op(a_Ext_op),
    .ALUctr(a_ALUctr), .nPC_sel(a_nPC_sel), .state(a_state),
    .instr_done(a_done), .instr_cnt(a_cnt));

  mc_ctrl #(.MEM_LAT(3), .ALUCTR_W(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(b_reset), .opcode(b_op), .funct(b_fn), .zero(b_zero),
    .PCWr(b_PCWr), .IRWr(b_IRWr), .RegWr(b_RegWr), .MemWr(b_MemWr),
    .RegDst(b_RegDst), .ALUSrc(b_ALUSrc), .MemtoReg(b_MemtoReg), .Ext_op(b_Ext_op),
    .ALUctr(b_ALUctr), .nPC_sel(b_nPC_sel), .state(b_state),
    .instr_done(b_done), .instr_cnt(b_cnt));

  mc_ctrl #(.MEM_LAT(2), .ALUCTR_W(3), .CNT_W(16)) u_c (
    .clk(clk), .reset(c_reset), .opcode(c_op), .funct(c_fn), .zero(c_zero),
    .PCWr(c_PCWr), .IRWr(c_IRWr), .RegWr(c_RegWr), .MemWr(c_MemWr),
    .RegDst(c_RegDst), .ALUSrc(c_ALUSrc), .MemtoReg(c_MemtoReg), .Ext_op(c_Ext_op),
    .ALUctr(c_ALUctr), .nPC_sel(c_nPC_sel), .state(c_state),
    .instr_done(c_done), .instr_cnt(c_cnt));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change just after the active edge, outputs are sampled mid-cycle
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_op = '0; a_fn = '0; b_op = '0; b_fn = '0; c_op = '0; c_fn = '0;
    a_zero = 1'b0; b_zero = 1'b0; c_zero = 1'b0;
    tick; tick;
    smp;
    chk("rst_state", a_state, 3'd0);
    chk("rst_strobes", {a_PCWr, a_IRWr, a_RegWr, a_MemWr}, 4'b0000);
    chk("rst_done", a_done, 1'b0);
    chk("rst_cnt", a_cnt, 4'd0);

    // addu, MEM_LAT=1
    tick; a_reset = 1'b0; a_op = 6'h00; a_fn = 6'h21;
    smp;  chk("addu_f_state", a_state, 3'd0);
    chk("addu_f_strobes", {a_PCWr, a_IRWr, a_RegWr, a_MemWr, a_nPC_sel}, 6'b110000);
    tick; smp; chk("addu_d_state", a_state, 3'd1); chk("addu_d_regwr", a_RegWr, 1'b0);
    tick; smp; chk("addu_e_state", a_state, 3'd2); chk("addu_e_regwr", a_RegWr, 1'b0);
    chk("addu_e_sel", {a_ALUSrc, a_ALUctr}, 4'b0000);
    tick; smp; chk("addu_wb_state", a_state, 3'd4);
    chk("addu_wb_ctl", {a_RegWr, a_RegDst, a_MemtoReg, a_done}, 6'b101001);
    tick; smp; chk("addu_cnt", a_cnt, 4'd1); chk("addu_next_state", a_state, 3'd0);

    // beq taken, then not taken
    a_op = 6'h04; a_fn = 6'h00; a_zero = 1'b1;
    tick; smp; chk("beq1_d_state", a_state, 3'd1);
    tick; smp; chk("beq1_e_state", a_state, 3'd2);
    chk("beq1_e_ctl", {a_PCWr, a_nPC_sel, a_done, a_ALUctr}, 7'b1011001);
    tick; smp; chk("beq1_cnt", a_cnt, 4'd2); chk("beq1_next", a_state, 3'd0);
    a_zero = 1'b0;
    tick; smp; chk("beq0_d_state", a_state, 3'd1);
    tick; smp; chk("beq0_e_ctl", {a_PCWr, a_nPC_sel, a_done}, 4'b0011);
    tick; smp; chk("beq0_cnt", a_cnt, 4'd3); chk("beq0_next", a_state, 3'd0);

    // jal
    a_op = 6'h03;
    tick; smp; chk("jal_d_state", a_state, 3'd1);
    chk("jal_d_ctl", {a_PCWr, a_RegWr, a_MemWr, a_RegDst, a_MemtoReg, a_nPC_sel, a_done},
        10'b1101010101);
    tick; smp; chk("jal_next", a_state, 3'd0); chk("jal_cnt", a_cnt, 4'd4);

    // CNT_W=4 wraps after 16 retired j instructions
    a_reset = 1'b1; a_op = 6'h02;
    tick; a_reset = 1'b0;
    smp; chk("wrap_rst_cnt", a_cnt, 4'd0);
    for (int i = 0; i < 15; i++) begin tick; tick; end
    smp; chk("wrap_cnt15", a_cnt, 4'd15);
    tick; smp; chk("wrap_j_done", {a_state, a_done, a_PCWr, a_nPC_sel}, 7'b0011110);
    tick; smp; chk("wrap_cnt0", a_cnt, 4'd0);

    // undefined opcode 0x3F
    a_op = 6'h3F; a_fn = 6'h00;
    tick; smp; chk("undef_d_state", a_state, 3'd1);
`ifdef MC_CTRL_TRAP_EN
    chk("undef_d_done", a_done, 1'b0);
    tick;
    for (int i = 0; i < 20; i++) begin
      smp;
      chk("trap_state", a_state, 3'd5);
      chk("trap_quiet", {a_PCWr, a_IRWr, a_RegWr, a_MemWr, a_done}, 5'b00000);
      chk("trap_cnt", a_cnt, 4'd0);
      tick;
    end
    a_reset = 1'b1;
    smp; chk("trap_rst_quiet", {a_PCWr, a_IRWr, a_RegWr, a_MemWr, a_done}, 5'b00000);
    tick; smp; chk("trap_rst_state", a_state, 3'd0);
`else
    chk("undef_d_ctl", {a_PCWr, a_IRWr, a_RegWr, a_MemWr, a_done}, 5'b00001);
    tick; smp; chk("undef_next", a_state, 3'd0); chk("undef_cnt", a_cnt, 4'd1);
`endif

    // lw then sw, MEM_LAT=3
    tick; b_reset = 1'b0; b_op = 6'h23;
    for (int i = 1; i <= 3; i++) begin
      smp; chk("lw_f_state", b_state, 3'd0); chk("lw_f_irwr", b_IRWr, 1'(i == 3)); tick;
    end
    smp; chk("lw_d_state", b_state, 3'd1); tick;
    smp; chk("lw_e_sel", {b_state, b_ALUSrc, b_Ext_op}, 6'b010101); tick;
    for (int i = 1; i <= 3; i++) begin
      smp; chk("lw_mem", {b_state, b_MemWr, b_RegWr}, 5'b01100); tick;
    end
    smp; chk("lw_wb", {b_state, b_RegWr, b_MemtoReg, b_done}, 7'b1001011);
    tick; b_op = 6'h2B;
    for (int i = 1; i <= 3; i++) begin
      smp;
      if (i == 1) chk("lw_cnt", b_cnt, 16'd1);
      chk("sw_f_irwr", {b_state, b_IRWr}, {3'd0, 1'(i == 3)});
      tick;
    end
    smp; chk("sw_d_state", b_state, 3'd1); tick;
    smp; chk("sw_e_state", b_state, 3'd2); tick;
    for (int i = 1; i <= 3; i++) begin
      smp; chk("sw_mem", {b_state, b_MemWr, b_RegWr, b_done}, {3'd3, 1'(i == 3), 1'b0, 1'(i == 3)});
      tick;
    end
    smp; chk("sw_next", b_state, 3'd0); chk("sw_cnt", b_cnt, 16'd2);

    // reset on first MEM cycle of sw, MEM_LAT=2
    tick; c_reset = 1'b0; c_op = 6'h2B;
    tick; tick; tick; tick;
    c_reset = 1'b1;
    smp; chk("swrst_m1", {c_state, c_MemWr}, 4'b0110);
    tick; c_reset = 1'b0;
    smp; chk("swrst_next", {c_state, c_MemWr, c_done}, 5'b00000);
    tick; smp; chk("swrst_f2", {c_state, c_IRWr, c_MemWr}, 5'b00010);
    chk("swrst_cnt", c_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MEM_LAT, 1, cycles per memory access (instruction fetch and data access); legal range 1..15.
- ALUCTR_W, 3, width of ALUctr.
- CNT_W, 16, width of the retired-instruction counter.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- opcode, in, 6, IR[31:26]; stable from DECODE until the instruction ends.
- funct, in, 6, IR[5:0].
- zero, in, 1, ALU equality flag.
- PCWr, out, 1, PC write strobe.
- IRWr, out, 1, IR write strobe.
- RegWr, out, 1, GRF write strobe.
- MemWr, out, 1, DM write strobe.
- RegDst, out, 2, write register select: 0 rt, 1 rd, 2 $31.
- ALUSrc, out, 1, ALU B select: 0 reg, 1 extended immediate.
- MemtoReg, out, 2, write-data select: 0 ALU, 1 lw, 2 PC, 3 lh.
- Ext_op, out, 2, extender mode: 0 zero, 1 sign, 2 lui.
- ALUctr, out, ALUCTR_W, ALU op: 0 add, 1 sub, 2 or, 3 lui, 4 slt.
- nPC_sel, out, 2, next-PC select: 0 PC+4, 1 branch, 2 j/jal, 3 jr.
- state, out, 3, current FSM state.
- instr_done, out, 1, last cycle of an instruction.
- instr_cnt, out, CNT_W, count of retired instructions.

Function
REQ-003 Supported instructions: addu, subu, slt, or, ori, lw, sw, beq, lui, lh, j, jal, jr; every other opcode/funct combination is undefined.
REQ-004 Datapath selects (RegDst, ALUSrc, MemtoReg, Ext_op, ALUctr) are combinational decodes of opcode/funct in every state, with the encodings of REQ-002.
REQ-005 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 return to FETCH on the next cycle with all strobes low.
REQ-006 FETCH holds for MEM_LAT cycles using wait counter cnt; on its final cycle it asserts IRWr=1, PCWr=1 and nPC_sel=0, then moves to DECODE.
REQ-007 DECODE transitions, each lasting 1 cycle:
- j: PCWr=1, nPC_sel=2, next state FETCH.
- jal: additionally RegWr=1, RegDst=2, MemtoReg=2.
- jr: PCWr=1, nPC_sel=3, next state FETCH.
- undefined: per REQ-015.
- all others: next state EXEC.
REQ-008 EXEC lasts 1 cycle, then:
- ALU-type: to WB.
- lw, lh, sw: to MEM.
- beq: PCWr=zero, nPC_sel=1, then to FETCH.
REQ-009 MEM holds for MEM_LAT cycles; MemWr=1 only on its final cycle and only for sw. Then sw goes to FETCH; lw and lh go to WB.
REQ-010 WB lasts 1 cycle with RegWr=1, then goes to FETCH.
REQ-011 Cycle counts with MEM_LAT=L:
- ALU-type: L+3.
- lw/lh: 2L+3.
- sw: 2L+2.
- beq: L+2.
- j/jal/jr: L+1.
REQ-012 Strobes are low in every state/cycle not listed above; at most one of MemWr and RegWr is high in any cycle.
REQ-013 instr_done=1 exactly on the cycle whose next state is FETCH from DECODE, EXEC, MEM or WB.
REQ-014 instr_cnt increments by 1 on each instr_done cycle and wraps modulo 2^CNT_W.

Reset
REQ-016 When reset=1 at a clk edge, on that edge:
- state <= FETCH, cnt <= 0, instr_cnt <= 0.
- An in-flight instruction is abandoned with no further strobes.
REQ-017 While reset is high, all strobes, instr_done and the trap indication are 0; reset takes priority over every transition, including TRAP.

Configuration
REQ-015 Macro MC_CTRL_TRAP_EN controls undefined-instruction handling:
- Defined: an undefined instruction in DECODE goes to TRAP. TRAP holds until reset with all strobes low, state=5, and instr_cnt not incremented.
- Undefined: an undefined instruction executes as a 1-cycle DECODE nop (no strobes, instr_done=1, next state FETCH), and TRAP is unreachable.

Verification
REQ-018 MEM_LAT=1, addu (opcode 0, funct 0x21): state 0,1,2,4; RegWr=1, RegDst=1 only in WB; instr_done at cycle 4; instr_cnt=1.
REQ-019 MEM_LAT=3, lw (0x23): FETCH 3 cycles, IRWr on the 3rd; MEM 3 cycles; WB RegWr=1, MemtoReg=1; 9 cycles total. Repeat with sw (0x2B): MemWr=1 only on the 3rd MEM cycle; 8 cycles total.
REQ-020 beq (0x04): zero=1 gives PCWr=1, nPC_sel=1 in EXEC; zero=0 gives PCWr=0; both take L+2 cycles.
REQ-021 jal (0x03): in DECODE, PCWr=RegWr=1, RegDst=2, MemtoReg=2, nPC_sel=2; next state FETCH.
REQ-022 Opcode 0x3F: with MC_CTRL_TRAP_EN, state=5 for 20 cycles until reset, then FETCH. Without the macro, DECODE nop and instr_cnt+1.
REQ-023 MEM_LAT=2, reset asserted on the 1st MEM cycle of sw gives MemWr never high and state=0 next; CNT_W=4 with 16 instructions gives instr_cnt wrapping to 0.
